alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 20 ++
 rtl/alu_arbiter_if.sv | 41 ++++
 rtl/alu_arbiter_alu.sv | 28 ++
 rtl/alu_arbiter.sv | 100 ++++++++++
 tb/tb_alu_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: datapath width, ALU op codes
// and FSM state encodings.
package alu_arbiter_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = alu_arbiter_pkg::WIDTH
);

  // Handshake: a request transfers on a cycle where reqN_valid and reqN_ready are
  // both high; valid must stay high with stable op/a/b until that cycle, and the
  // result comes back later as a one-cycle rspN_valid pulse with rsp_data/rsp_cout.
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cout;
  logic             busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_cout, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_cout, busy
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Shared 16-bit ALU: add, subtract (a-b via a + ~b + 1), AND, OR.
// cout is the raw adder carry; callers mask it for logic ops.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] i0_i,
  input  logic [WIDTH-1:0] i1_i,
  output logic [WIDTH-1:0] o_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  always_comb begin
    // op[0] selects subtract: invert b and use it as the carry-in
    b_eff  = op_i[0] ? ~i1_i : i1_i;
    sum    = {1'b0, i0_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_i[0]};
    cout_o = sum[WIDTH];
    case (op_i)
      OP_AND:  o_o = i0_i & i1_i;
      OP_OR:   o_o = i0_i | i1_i;
      default: o_o = sum[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters:
// IDLE accepts one request, EXEC computes from latched operands, RESP pulses the result.
module alu_arbiter #(
  parameter int WIDTH = alu_arbiter_pkg::WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_arbiter_if.slave            bus,
  output alu_arbiter_pkg::state_e dbg_state_o
);

  import alu_arbiter_pkg::*;

  state_e           state_q, state_d;
  logic             last_grant_q;
  logic             gnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_cout_q;

  logic             sel;
  logic             load;
  logic [WIDTH-1:0] alu_o;
  logic             alu_cout;

  // On a tie the port not served last time wins; otherwise the lone valid port.
  assign sel = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

  alu_arbiter_alu u_alu (
    .op_i   (op_q),
    .i0_i   (a_q),
    .i1_i   (b_q),
    .o_o    (alu_o),
    .cout_o (alu_cout)
  );

  // Every output is held low while reset is high so an abandoned op never responds.
  always_comb begin
    state_d        = state_q;
    load           = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.busy       = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          bus.req0_ready = bus.req0_valid & ~sel;
          bus.req1_ready = bus.req1_valid & sel;
          load           = bus.req0_valid | bus.req1_valid;
          if (load) state_d = EXEC;
        end
        EXEC: begin
          bus.busy = 1'b1;
          state_d  = RESP;
        end
        RESP: begin
          bus.busy       = 1'b1;
          bus.rsp0_valid = ~gnt_q;
          bus.rsp1_valid = gnt_q;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      op_q         <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
      rsp_cout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        gnt_q        <= sel;
        last_grant_q <= sel;
        op_q         <= sel ? bus.req1_op : bus.req0_op;
        a_q          <= sel ? bus.req1_a  : bus.req0_a;
        b_q          <= sel ? bus.req1_b  : bus.req0_b;
      end
      if (state_q == EXEC) begin
        rsp_data_q <= alu_o;
        rsp_cout_q <= alu_cout & ~op_q[1];
      end
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_cout = rsp_cout_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked every cycle
// against a timing/arithmetic reference model of the arbiter's behaviour.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_e dbg_state;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  req_t pq0[$];
  req_t pq1[$];
  logic [W+1:0] exp_q[$];   // {port, cout, data}
  int           due_q[$];
  logic [W+1:0] obs_log[$];
  int           acc_port[$];
  int           acc_cyc[$];

  int           free_at = 0;
  int           last_g  = 1;
  logic [W-1:0] held_data = '0;
  logic         held_cout = 1'b0;
  bit           known = 1'b0;

  function automatic logic [W:0] ref_alu(input req_t r);
    int unsigned x, y, s;
    logic c;
    x = r.a;
    y = r.b;
    s = 0;
    c = 1'b0;
    case (r.op)
      OP_ADD: begin s = (x + y) % 65536; c = ((x + y) >= 65536); end
      OP_SUB: begin s = (x + 65536 - y) % 65536; c = (x >= y); end
      OP_AND: s = x & y;
      default: s = x | y;
    endcase
    return {c, s[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.op = 2'($urandom_range(0, 3));
    r.a  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
    r.b  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 65535));
    return r;
  endfunction

  task automatic drive();
    req_t j0, j1;
    j0 = rnd_req();
    j1 = rnd_req();
    if (pq0.size() > 0) j0 = pq0[0];
    if (pq1.size() > 0) j1 = pq1[0];
    bus.req0_valid = (pq0.size() > 0);
    bus.req0_op    = j0.op;
    bus.req0_a     = j0.a;
    bus.req0_b     = j0.b;
    bus.req1_valid = (pq1.size() > 0);
    bus.req1_op    = j1.op;
    bus.req1_a     = j1.a;
    bus.req1_b     = j1.b;
  endtask

  // One clock: drive, check at negedge against the model, advance model, step.
  task automatic cycle();
    logic e_r0, e_r1, e_v0, e_v1, e_busy;
    int   g;
    req_t r;
    drive();
    @(negedge clk);
    e_v0 = 1'b0;
    e_v1 = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      held_data = exp_q[0][W-1:0];
      held_cout = exp_q[0][W];
      if (!reset) begin
        if (exp_q[0][W+1]) e_v1 = 1'b1;
        else e_v0 = 1'b1;
      end
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
    e_busy = !reset && (free_at > cyc);
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    g    = -1;
    if (!reset && free_at <= cyc && (bus.req0_valid || bus.req1_valid)) begin
      if (bus.req0_valid && bus.req1_valid) g = 1 - last_g;
      else g = bus.req1_valid ? 1 : 0;
      if (g == 1) e_r1 = 1'b1;
      else e_r0 = 1'b1;
    end
    chk("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(e_v0));
    chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(e_v1));
    if (known) begin
      chk("rsp_data", 32'(bus.rsp_data), 32'(held_data));
      chk("rsp_cout", 32'(bus.rsp_cout), 32'(held_cout));
    end
    if (bus.rsp0_valid || bus.rsp1_valid)
      obs_log.push_back({bus.rsp1_valid, bus.rsp_cout, bus.rsp_data});
    if (g >= 0) begin
      if (g == 1) r = pq1.pop_front();
      else r = pq0.pop_front();
      exp_q.push_back({g[0], ref_alu(r)});
      due_q.push_back(cyc + 2);
      acc_port.push_back(g);
      acc_cyc.push_back(cyc);
      last_g  = g;
      free_at = cyc + 3;
    end
    if (reset) begin
      exp_q.delete();
      due_q.delete();
      held_data = '0;
      held_cout = 1'b0;
      known     = 1'b1;
      free_at   = cyc + 1;
      last_g    = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((pq0.size() > 0 || pq1.size() > 0 || due_q.size() > 0) && n < max_cyc) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(pq0.size() + pq1.size() + due_q.size()), 32'd0);
  endtask

  task automatic clr_logs();
    obs_log.delete();
    acc_port.delete();
    acc_cyc.delete();
  endtask

  initial begin
    drive();
    @(posedge clk);
    #1;

    // reset state
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_data", 32'(bus.rsp_data), 32'h0);
    cycle();
    cycle();

    // port 0 add with carry-out
    clr_logs();
    pq0.push_back('{op: OP_ADD, a: 16'hFFFF, b: 16'h0001});
    drain(20);
    chk("add_count", 32'(obs_log.size()), 32'd1);
    chk("add_rsp", 32'(obs_log[0]), 32'({1'b0, 1'b1, 16'h0000}));
    chk("add_acc_t", 32'(acc_cyc[0]), 32'(cyc - 3));

    // port 1 subtract both directions
    clr_logs();
    pq1.push_back('{op: OP_SUB, a: 16'h0005, b: 16'h0007});
    pq1.push_back('{op: OP_SUB, a: 16'h0007, b: 16'h0005});
    drain(20);
    chk("sub_borrow", 32'(obs_log[0]), 32'({1'b1, 1'b0, 16'hFFFE}));
    chk("sub_noborrow", 32'(obs_log[1]), 32'({1'b1, 1'b1, 16'h0002}));

    // tie from first post-reset cycle, then another tie
    clr_logs();
    pq0.push_back('{op: OP_AND, a: 16'hF0F0, b: 16'hFF00});
    pq1.push_back('{op: OP_OR,  a: 16'h000F, b: 16'h00F0});
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drain(20);
    chk("tie_p0", 32'(obs_log[0]), 32'({1'b0, 1'b0, 16'hF000}));
    chk("tie_p1", 32'(obs_log[1]), 32'({1'b1, 1'b0, 16'h00FF}));
    pq0.push_back(rnd_req());
    pq1.push_back(rnd_req());
    drain(20);
    chk("tie2_grant", 32'(acc_port[2]), 32'd0);

    // sustained contention alternates, one acceptance every 3 cycles
    clr_logs();
    for (int i = 0; i < 3; i++) begin
      pq0.push_back(rnd_req());
      pq1.push_back(rnd_req());
    end
    drain(40);
    for (int i = 0; i < 6; i++) chk("alt_grant", 32'(acc_port[i]), 32'(i % 2));
    for (int i = 1; i < 6; i++) chk("alt_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);

    // reset while in EXEC abandons the op; pending port 1 is served after reset
    clr_logs();
    pq0.push_back('{op: OP_ADD, a: 16'h1111, b: 16'h2222});
    pq1.push_back('{op: OP_OR,  a: 16'h0A00, b: 16'h00B0});
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("exec_rst_state", 32'(dbg_state), 32'(IDLE));
    chk("exec_rst_data", 32'(bus.rsp_data), 32'h0);
    drain(20);
    chk("exec_rst_count", 32'(obs_log.size()), 32'd1);
    chk("exec_rst_rsp", 32'(obs_log[0]), 32'({1'b1, 1'b0, 16'h0AB0}));
    chk("exec_rst_reacc", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);

    // operands change right after handshake
    clr_logs();
    pq0.push_back('{op: OP_ADD, a: 16'h1234, b: 16'h0101});
    drain(20);
    chk("latched_ops", 32'(obs_log[0]), 32'({1'b0, 1'b0, 16'h1335}));

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && pq0.size() < 4) pq0.push_back(rnd_req());
      if ($urandom_range(0, 3) == 0 && pq1.size() < 4) pq1.push_back(rnd_req());
      reset = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0;
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
